// File: rtl/snes_pad_scanner.sv
// Polls two SNES serial gamepads over a shared latch/clock, debounces the
// 16-bit reports and presents turbo-processed 10-bit NES button vectors.
module snes_pad_scanner #(
  parameter int POLL_CYC  = 29830,
  parameter int LATCH_CYC = 22,
  parameter int HALF_CYC  = 11,
  parameter int DEBOUNCE  = 2,
  parameter int TURBO_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scan_en,
  output logic       o_pad_latch,
  output logic       o_pad_clk,
  input  logic       i_pad_data_1p,
  input  logic       i_pad_data_2p,
  output logic [9:0] o_jp_vec_1p,
  output logic [9:0] o_jp_vec_2p,
  output logic       o_scan_busy,
  output logic       o_scan_done
);
  localparam int PW   = $clog2(POLL_CYC);
  localparam int TMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYC - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYC - 1);
  localparam logic [2:0]    DEB_MIN    = 3'(DEBOUNCE);
  localparam logic [3:0]    TURBO_LAST = 4'(TURBO_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_BIT0, S_CLK_LO, S_CLK_HI, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [PW-1:0]        r_poll;
  logic [TW-1:0]        r_tmr;
  logic [3:0]           r_bit;
  logic [3:0]           r_scn;
  logic                 r_phase;
  logic                 w_sample, w_phase_nxt;
  logic [1:0][1:0]      r_sync;
  logic [1:0][15:0]     r_sh;
  logic [1:0][9:0]      r_prev, r_stab, r_vec;
  logic [1:0][2:0]      r_cnt;
  logic [1:0][9:0]      w_cand, w_stab_nxt, w_vec_nxt;
  logic [1:0][2:0]      w_cnt_nxt;

  // SNES report order -> {Y,X,Right,Left,Down,Up,Start,Sel,B,A}
  function automatic logic [9:0] f_cand(input logic [15:0] s);
    return {s[1], s[9], s[7], s[6], s[5], s[4], s[3], s[2], s[0], s[8]};
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_sample    = 1'b0;
    o_pad_latch = 1'b0;
    o_pad_clk   = 1'b1;
    o_scan_busy = 1'b1;
    o_scan_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_scan_busy = 1'b0;
        if (i_scan_en && r_poll == POLL_LAST) w_next = S_LATCH;
      end
      S_LATCH: begin
        o_pad_latch = 1'b1;
        if (r_tmr == LATCH_LAST) w_next = S_BIT0;
      end
      S_BIT0: if (r_tmr == HALF_LAST) begin
        w_sample = 1'b1;
        w_next   = S_CLK_LO;
      end
      S_CLK_LO: begin
        o_pad_clk = 1'b0;
        if (r_tmr == HALF_LAST) w_next = S_CLK_HI;
      end
      S_CLK_HI: if (r_tmr == HALF_LAST) begin
        w_sample = 1'b1;
        w_next   = (r_bit == 4'd15) ? S_DONE : S_CLK_LO;
      end
      S_DONE: begin
        o_scan_done = 1'b1;
        w_next      = S_IDLE;
      end
      default: begin
        o_scan_busy = 1'b0;
        w_next      = S_IDLE;
      end
    endcase
  end

  assign w_phase_nxt = (r_scn == TURBO_LAST) ? ~r_phase : r_phase;

  always_comb begin
    w_cand     = '0;
    w_cnt_nxt  = '0;
    w_stab_nxt = '0;
    w_vec_nxt  = '0;
    for (int p = 0; p < 2; p++) begin
      w_cand[p] = f_cand(r_sh[p]);
      if (w_cand[p] == r_prev[p])
        w_cnt_nxt[p] = (r_cnt[p] == 3'd7) ? 3'd7 : r_cnt[p] + 3'd1;
      else
        w_cnt_nxt[p] = 3'd1;
      w_stab_nxt[p] = (w_cnt_nxt[p] >= DEB_MIN) ? w_cand[p] : r_stab[p];
      // Turbo X/Y fold into A/B with the phase that this same scan produces
      w_vec_nxt[p]  = w_stab_nxt[p] |
                      {8'b0, w_stab_nxt[p][9] & w_phase_nxt, w_stab_nxt[p][8] & w_phase_nxt};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_poll  <= '0;
      r_tmr   <= '0;
      r_bit   <= '0;
      r_scn   <= '0;
      r_phase <= 1'b0;
      r_sync  <= '1;
      r_sh    <= '0;
      r_prev  <= '0;
      r_stab  <= '0;
      r_vec   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync[0] <= {r_sync[0][0], i_pad_data_1p};
      r_sync[1] <= {r_sync[1][0], i_pad_data_2p};
      if (r_state == S_IDLE)
        r_poll <= (!i_scan_en || r_poll == POLL_LAST) ? '0 : r_poll + 1'b1;
      if (r_state == S_IDLE || w_next != r_state) r_tmr <= '0;
      else                                        r_tmr <= r_tmr + 1'b1;
      if (w_sample) begin
        r_bit   <= r_bit + 4'd1;
        r_sh[0] <= {~r_sync[0][1], r_sh[0][15:1]};
        r_sh[1] <= {~r_sync[1][1], r_sh[1][15:1]};
      end
      if (r_state == S_DONE) begin
        r_scn   <= (r_scn == TURBO_LAST) ? 4'd0 : r_scn + 4'd1;
        r_phase <= w_phase_nxt;
        r_prev  <= w_cand;
        r_cnt   <= w_cnt_nxt;
        r_stab  <= w_stab_nxt;
        r_vec   <= w_vec_nxt;
      end
    end
  end

  assign o_jp_vec_1p = r_vec[0];
  assign o_jp_vec_2p = r_vec[1];
endmodule

// File: tb/tb_snes_pad_scanner.sv
// Scoreboard bench for snes_pad_scanner: behavioural SNES pads, expected
// vectors queued per scan and checked by an independent monitor.
module tb_snes_pad_scanner;
  logic       clk = 1'b0;
  logic       i_rst, i_scan_en;
  logic       o_pad_latch, o_pad_clk;
  logic       i_pad_data_1p, i_pad_data_2p;
  logic [9:0] o_jp_vec_1p, o_jp_vec_2p;
  logic       o_scan_busy, o_scan_done;

  snes_pad_scanner #(.POLL_CYC(400), .LATCH_CYC(4), .HALF_CYC(4), .DEBOUNCE(2), .TURBO_DIV(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_scan_en(i_scan_en),
    .o_pad_latch(o_pad_latch), .o_pad_clk(o_pad_clk),
    .i_pad_data_1p(i_pad_data_1p), .i_pad_data_2p(i_pad_data_2p),
    .o_jp_vec_1p(o_jp_vec_1p), .o_jp_vec_2p(o_jp_vec_2p),
    .o_scan_busy(o_scan_busy), .o_scan_done(o_scan_done)
  );

  always #5 clk = ~clk;

  // Pad model: latch loads the button state, each clk rise presents the next bit
  logic [15:0] btn1 = '0, btn2 = '0, sh1 = '0, sh2 = '0;
  always @(posedge o_pad_latch or posedge o_pad_clk) begin
    if (o_pad_latch) begin sh1 = btn1; sh2 = btn2; end
    else begin sh1 = sh1 >> 1; sh2 = sh2 >> 1; end
  end
  assign i_pad_data_1p = ~sh1[0];
  assign i_pad_data_2p = ~sh2[0];

  int cyc = 0;
  always @(posedge clk) cyc <= i_rst ? 0 : cyc + 1;

  typedef struct packed { logic [9:0] v1; logic [9:0] v2; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: vectors settle on the edge that ends the done strobe
  always @(negedge clk) begin
    exp_t e;
    if (!i_rst && o_scan_done === 1'b1) begin
      @(negedge clk);
      chk("done_pulse_width", {31'b0, o_scan_done}, 32'd0);
      if (sb.size() == 0) chk("unexpected_scan_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("vec_1p", {22'b0, o_jp_vec_1p}, {22'b0, e.v1});
        chk("vec_2p", {22'b0, o_jp_vec_2p}, {22'b0, e.v2});
      end
    end
  end

  task automatic wait_latch(output bit ok);
    int n = 0;
    while (o_pad_latch !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
    ok = (o_pad_latch === 1'b1);
    if (!ok) chk("latch_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_scan(input logic [15:0] b1, input logic [15:0] b2,
                          input logic [9:0] e1, input logic [9:0] e2,
                          input int exp_rise, input bit drop_en);
    bit ok;
    int n, lat_n, clk_n;
    logic pclk;
    btn1 = b1; btn2 = b2;
    sb.push_back({e1, e2});
    wait_latch(ok);
    if (ok) begin
      if (exp_rise >= 0) chk("latch_rise_cycle", cyc, exp_rise);
      chk("busy_at_latch", {31'b0, o_scan_busy}, 32'd1);
      lat_n = 0; clk_n = 0; n = 0; pclk = o_pad_clk;
      while (o_scan_done !== 1'b1 && n < 400) begin
        if (o_pad_latch) lat_n++;
        if (pclk && !o_pad_clk) clk_n++;
        pclk = o_pad_clk;
        if (drop_en && n == 20) i_scan_en = 1'b0;
        @(negedge clk); n++;
      end
      if (o_scan_done !== 1'b1) chk("done_timeout", 32'd1, 32'd0);
      else begin
        chk("latch_high_cycles", lat_n, 4);
        chk("clk_low_pulses", clk_n, 15);
        chk("busy_at_done", {31'b0, o_scan_busy}, 32'd1);
        if (exp_rise >= 0) chk("done_cycle", cyc, exp_rise + 128);
      end
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
  endtask

  initial begin
    bit ok;
    int n, falls, rises;
    logic pclk, plat;
    i_rst = 1'b1; i_scan_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_latch", {31'b0, o_pad_latch}, 32'd0);
    chk("rst_clk",   {31'b0, o_pad_clk},   32'd1);
    chk("rst_busy",  {31'b0, o_scan_busy}, 32'd0);
    chk("rst_done",  {31'b0, o_scan_done}, 32'd0);
    chk("rst_vec_1p", {22'b0, o_jp_vec_1p}, 32'd0);
    chk("rst_vec_2p", {22'b0, o_jp_vec_2p}, 32'd0);
    i_rst = 1'b0;

    // Idle pads, then A+Start, release, then alternating A/none
    run_scan(16'h0000, 16'h0000, 10'h000, 10'h000, 400, 1'b0);
    run_scan(16'h0108, 16'h0000, 10'h000, 10'h000, -1, 1'b0);
    run_scan(16'h0108, 16'h0000, 10'h009, 10'h000, -1, 1'b0);
    run_scan(16'h0000, 16'h0000, 10'h009, 10'h000, -1, 1'b0);
    run_scan(16'h0000, 16'h0000, 10'h000, 10'h000, -1, 1'b0);
    run_scan(16'h0100, 16'h0000, 10'h000, 10'h000, -1, 1'b0);
    run_scan(16'h0000, 16'h0000, 10'h000, 10'h000, -1, 1'b0);
    run_scan(16'h0100, 16'h0000, 10'h000, 10'h000, -1, 1'b0);
    run_scan(16'h0000, 16'h0000, 10'h000, 10'h000, -1, 1'b0);
    run_scan(16'h0100, 16'h0000, 10'h000, 10'h000, -1, 1'b0);
    run_scan(16'h0100, 16'h0000, 10'h001, 10'h000, -1, 1'b0);

    // Reset during the 7th clk low phase aborts the scan
    wait_latch(ok);
    falls = 0; n = 0; pclk = o_pad_clk;
    while (ok && falls < 7 && n < 400) begin
      @(negedge clk); n++;
      if (pclk && !o_pad_clk) falls++;
      pclk = o_pad_clk;
    end
    chk("abort_reached_bit7", falls, 7);
    i_rst = 1'b1;
    @(negedge clk);
    chk("abort_latch", {31'b0, o_pad_latch}, 32'd0);
    chk("abort_clk",   {31'b0, o_pad_clk},   32'd1);
    chk("abort_busy",  {31'b0, o_scan_busy}, 32'd0);
    chk("abort_vec_1p", {22'b0, o_jp_vec_1p}, 32'd0);
    chk("abort_vec_2p", {22'b0, o_jp_vec_2p}, 32'd0);
    i_rst = 1'b0;

    // X held from a fresh reset: turbo A follows 0,1,1,0,0,1,1
    run_scan(16'h0200, 16'h0000, 10'h000, 10'h000, 400, 1'b0);
    run_scan(16'h0200, 16'h0000, 10'h101, 10'h000, -1, 1'b0);
    run_scan(16'h0200, 16'h0000, 10'h101, 10'h000, -1, 1'b0);
    run_scan(16'h0200, 16'h0000, 10'h100, 10'h000, -1, 1'b0);
    run_scan(16'h0200, 16'h0000, 10'h100, 10'h000, -1, 1'b0);
    run_scan(16'h0200, 16'h0000, 10'h101, 10'h000, -1, 1'b0);
    run_scan(16'h0200, 16'h0000, 10'h101, 10'h000, -1, 1'b0);

    // 2p Right+B, then polling disabled mid-scan
    run_scan(16'h0000, 16'h0081, 10'h100, 10'h000, -1, 1'b0);
    run_scan(16'h0000, 16'h0081, 10'h000, 10'h082, -1, 1'b0);
    run_scan(16'h0000, 16'h0081, 10'h000, 10'h082, -1, 1'b1);
    rises = 0; plat = o_pad_latch;
    repeat (1000) begin
      @(negedge clk);
      if (!plat && o_pad_latch) rises++;
      plat = o_pad_latch;
    end
    chk("no_latch_after_disable", rises, 0);
    chk("idle_busy", {31'b0, o_scan_busy}, 32'd0);
    chk("hold_vec_2p", {22'b0, o_jp_vec_2p}, 32'h082);
    chk("hold_vec_1p", {22'b0, o_jp_vec_1p}, 32'h000);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
